// File: rtl/id_rf_pkg.sv
// id_rf_pkg: shared payload layout, NOP opcode and occupancy encoding for the ID->RF skid stage.
package id_rf_pkg;
    localparam int ID_RF_PAYLOAD_W   = 72;
    localparam int ID_RF_IMMCTL_LSB  = 0;
    localparam int ID_RF_IMM6_LSB    = 1;
    localparam int ID_RF_IMM9_LSB    = 7;
    localparam int ID_RF_DEST_LSB    = 16;
    localparam int ID_RF_SRC2_LSB    = 19;
    localparam int ID_RF_SRC1_LSB    = 23;
    localparam int ID_RF_OPC_LSB     = 27;
    localparam int ID_RF_OPC_W       = 4;
    localparam int ID_RF_EX_LSB      = 31;
    localparam int ID_RF_MEM_LSB     = 35;
    localparam int ID_RF_WB_LSB      = 37;
    localparam int ID_RF_PC1_LSB     = 40;
    localparam int ID_RF_PC_LSB      = 56;
    localparam logic [3:0] ID_RF_NOP_OPC = 4'b1111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;
endpackage

// File: rtl/id_rf_group_entry.sv
// id_rf_group_entry: one held instruction group; invalid lanes read back as a NOP word.
module id_rf_group_entry
    import id_rf_pkg::*;
#(
    parameter int         LANES     = 2,
    parameter int         PAYLOAD_W = ID_RF_PAYLOAD_W,
    parameter int         OPC_LSB   = ID_RF_OPC_LSB,
    parameter logic [3:0] NOP_OPC   = ID_RF_NOP_OPC
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       load_i,
    input  logic                       clear_i,
    input  logic [LANES-1:0]           load_valid_i,
    input  logic [LANES*PAYLOAD_W-1:0] load_payload_i,
    input  logic [LANES-1:0]           kill_i,
    output logic [LANES-1:0]           valid_o,
    output logic [LANES*PAYLOAD_W-1:0] payload_o
);
    localparam logic [PAYLOAD_W-1:0] NOP_WORD = {{(PAYLOAD_W-4){1'b0}}, NOP_OPC} << OPC_LSB;

    logic [LANES-1:0]           valid_q, valid_d;
    logic [LANES*PAYLOAD_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = clear_i ? '0 : load_i ? load_valid_i : valid_q & ~kill_i;
        data_d  = load_i ? load_payload_i : data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign payload_o[l*PAYLOAD_W +: PAYLOAD_W] = valid_q[l] ? data_q[l*PAYLOAD_W +: PAYLOAD_W] : NOP_WORD;
    end

    assign valid_o = valid_q;
endmodule

// File: rtl/id_rf_skid_stage.sv
// id_rf_skid_stage: ID->RF group register with a 2-entry skid buffer, valid/ready handshake,
// flush and per-lane kill of held groups.
module id_rf_skid_stage
    import id_rf_pkg::*;
#(
    parameter int         LANES     = 2,
    parameter int         PAYLOAD_W = ID_RF_PAYLOAD_W,
    parameter int         OPC_LSB   = ID_RF_OPC_LSB,
    parameter logic [3:0] NOP_OPC   = ID_RF_NOP_OPC
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [LANES-1:0]           kill_mask_i,
    input  logic [LANES-1:0]           in_valid_i,
    input  logic [LANES*PAYLOAD_W-1:0] in_payload_i,
    output logic                       in_ready_o,
    output logic [LANES-1:0]           out_valid_o,
    output logic [LANES*PAYLOAD_W-1:0] out_payload_o,
    input  logic                       out_ready_i,
    output logic [1:0]                 occupancy_o
);
    occ_e                       state_q, state_d;
    logic                       push, pop, h_keep, t_keep, both_keep;
    logic                       head_load, head_clear, tail_load, tail_clear;
    logic [LANES-1:0]           tail_valid, head_load_valid;
    logic [LANES*PAYLOAD_W-1:0] tail_payload, head_load_payload;

    assign in_ready_o  = !rst_i && state_q != ST_FULL;
    assign push        = in_ready_o & |in_valid_i;
    assign pop         = out_ready_i & |out_valid_o;
    assign occupancy_o = state_q;

    // Head survives only if not consumed and some lane outlives the kill; the tail is never consumed.
    always_comb begin
        h_keep            = state_q != ST_EMPTY && !pop && |(out_valid_o & ~kill_mask_i);
        t_keep            = state_q == ST_FULL;
        both_keep         = h_keep & t_keep;
        head_load         = !flush_i && !h_keep && (t_keep || push);
        head_clear        = flush_i || (!h_keep && !t_keep && !push);
        head_load_valid   = t_keep ? tail_valid & ~kill_mask_i : in_valid_i;
        head_load_payload = t_keep ? tail_payload : in_payload_i;
        tail_load         = !flush_i && h_keep && push;
        tail_clear        = flush_i || (!both_keep && !tail_load);
        state_d           = flush_i ? ST_EMPTY : occ_e'(2'(h_keep) + 2'(t_keep) + 2'(push));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    id_rf_group_entry #(.LANES(LANES), .PAYLOAD_W(PAYLOAD_W), .OPC_LSB(OPC_LSB), .NOP_OPC(NOP_OPC)) u_head (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .load_i         (head_load),
        .clear_i        (head_clear),
        .load_valid_i   (head_load_valid),
        .load_payload_i (head_load_payload),
        .kill_i         (kill_mask_i),
        .valid_o        (out_valid_o),
        .payload_o      (out_payload_o)
    );

    id_rf_group_entry #(.LANES(LANES), .PAYLOAD_W(PAYLOAD_W), .OPC_LSB(OPC_LSB), .NOP_OPC(NOP_OPC)) u_tail (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .load_i         (tail_load),
        .clear_i        (tail_clear),
        .load_valid_i   (in_valid_i),
        .load_payload_i (in_payload_i),
        .kill_i         (kill_mask_i),
        .valid_o        (tail_valid),
        .payload_o      (tail_payload)
    );
endmodule

// File: tb/tb_id_rf_skid_stage.sv
// tb_id_rf_skid_stage: directed scenarios plus randomized traffic against a queue model of held groups.
module tb_id_rf_skid_stage;
    localparam int L  = 2;
    localparam int W  = 72;
    localparam int LW = L * W;
    localparam logic [W-1:0] NOP_WORD = {{(W-4){1'b0}}, 4'hF} << 27;

    typedef struct packed {
        logic [L-1:0]  v;
        logic [LW-1:0] p;
    } grp_t;

    logic          clk = 0, rst = 1, flush = 0, out_ready = 0;
    logic [L-1:0]  kill = '0, in_valid = '0;
    logic [LW-1:0] in_payload = '0;
    logic          in_ready;
    logic [L-1:0]  out_valid;
    logic [LW-1:0] out_payload;
    logic [1:0]    occupancy;

    int   passed = 0, total = 0;
    grp_t q[$];
    logic [LW-1:0] ga, gb, gc;

    always #5 clk = ~clk;

    id_rf_skid_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .kill_mask_i   (kill),
        .in_valid_i    (in_valid),
        .in_payload_i  (in_payload),
        .in_ready_o    (in_ready),
        .out_valid_o   (out_valid),
        .out_payload_o (out_payload),
        .out_ready_i   (out_ready),
        .occupancy_o   (occupancy)
    );

    function automatic logic [LW-1:0] rnd();
        return LW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [LW-1:0] exp_pl(grp_t g);
        logic [LW-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = g.v[i] ? g.p[i*W +: W] : NOP_WORD;
        return r;
    endfunction

    task automatic chk(string n, logic [159:0] a, logic [159:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
        else passed++;
    endtask

    task automatic compare();
        grp_t h;
        h = q.size() != 0 ? q[0] : '0;
        chk("occupancy", 160'(occupancy), 160'(q.size()));
        chk("in_ready", 160'(in_ready), 160'(q.size() < 2));
        chk("out_valid", 160'(out_valid), 160'(h.v));
        chk("out_payload", 160'(out_payload), 160'(exp_pl(h)));
    endtask

    task automatic drive(logic fl, logic [L-1:0] km, logic [L-1:0] iv, logic [LW-1:0] ip, logic ordy);
        flush = fl; kill = km; in_valid = iv; in_payload = ip; out_ready = ordy;
    endtask

    // Model: ordered list of held groups; the head leaves on pop or when kill empties it.
    task automatic step();
        grp_t nq[$];
        grp_t g;
        bit   push, pop;
        if (!flush) begin
            push = q.size() < 2 && |in_valid;
            pop  = out_ready && q.size() > 0 && |q[0].v;
            for (int i = 0; i < q.size(); i++) begin
                g   = q[i];
                g.v = g.v & ~kill;
                if (!(i == 0 && (pop || g.v == '0))) nq.push_back(g);
            end
            if (push) begin
                g.v = in_valid;
                g.p = in_payload;
                nq.push_back(g);
            end
        end
        @(posedge clk);
        #1;
        q = nq;
        compare();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", 160'(occupancy), 160'(0));
        chk("rst_ready", 160'(in_ready), 160'(0));
        chk("rst_payload", 160'(out_payload), 160'({NOP_WORD, NOP_WORD}));
        #3 rst = 0;
        #1 chk("rel_ready", 160'(in_ready), 160'(1));

        // Reset while FULL
        ga = rnd(); gb = rnd();
        drive(0, 0, 2'b11, ga, 0); step();
        drive(0, 0, 2'b11, gb, 0); step();
        chk("t1_full", 160'(occupancy), 160'(2));
        #2 rst = 1;
        #1;
        chk("t1_occ", 160'(occupancy), 160'(0));
        chk("t1_valid", 160'(out_valid), 160'(0));
        chk("t1_opc", 160'({out_payload[W+27 +: 4], out_payload[27 +: 4]}), 160'(8'hFF));
        chk("t1_ready", 160'(in_ready), 160'(0));
        q.delete();
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst = 0;
        #1 chk("t1_rel_ready", 160'(in_ready), 160'(1));

        // Back-pressure then drain in order
        ga = rnd(); gb = rnd(); gc = rnd();
        drive(0, 0, 2'b11, ga, 0); step();
        chk("t2_headA", 160'(out_payload), 160'(ga));
        drive(0, 0, 2'b11, gb, 0); step();
        chk("t2_noready", 160'(in_ready), 160'(0));
        drive(0, 0, 2'b11, gc, 0); step();
        chk("t2_held", 160'(occupancy), 160'(2));
        drive(0, 0, 2'b11, gc, 1); step();
        chk("t2_headB", 160'(out_payload), 160'(gb));
        drive(0, 0, 2'b11, gc, 1); step();
        chk("t2_headC", 160'(out_payload), 160'(gc));
        drive(0, 0, 0, 0, 1); step();
        chk("t2_empty", 160'(occupancy), 160'(0));

        // Streaming push+pop
        for (int i = 0; i < 8; i++) begin
            ga = rnd();
            drive(0, 0, 2'b11, ga, 1); step();
            chk("t3_occ", 160'(occupancy), 160'(1));
            chk("t3_head", 160'(out_payload), 160'(ga));
        end
        drive(0, 0, 0, 0, 1); step();

        // Kill
        ga = rnd(); gb = rnd();
        drive(0, 0, 2'b11, ga, 0); step();
        drive(0, 2'b10, 0, 0, 0); step();
        chk("t4_valid", 160'(out_valid), 160'(2'b01));
        chk("t4_opc1", 160'(out_payload[W+27 +: 4]), 160'(4'hF));
        drive(0, 0, 2'b11, gb, 0); step();
        drive(0, 2'b11, 0, 0, 0); step();
        chk("t4_drop_occ", 160'(occupancy), 160'(1));
        drive(0, 0, 0, 0, 0); step();

        // Flush
        ga = rnd(); gb = rnd(); gc = rnd();
        drive(0, 0, 2'b11, ga, 0); step();
        drive(0, 0, 2'b11, gb, 0); step();
        drive(1, 0, 2'b11, gc, 0); step();
        chk("t5_occ", 160'(occupancy), 160'(0));
        chk("t5_valid", 160'(out_valid), 160'(0));
        drive(0, 0, 2'b11, ga, 0); step();
        drive(1, 2'b01, 2'b11, gc, 1); step();
        chk("t5_one_occ", 160'(occupancy), 160'(0));

        // Partial and empty groups
        ga = rnd();
        drive(0, 0, 2'b01, ga, 0); step();
        chk("t6_valid", 160'(out_valid), 160'(2'b01));
        chk("t6_lane1", 160'(out_payload[W +: W]), 160'(NOP_WORD));
        drive(0, 0, 0, rnd(), 1); step();
        drive(0, 0, 0, rnd(), 0); step();
        chk("t6_empty", 160'(occupancy), 160'(0));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(31) == 0, $urandom_range(7) == 0 ? L'($urandom) : '0,
                  L'($urandom), rnd(), $urandom_range(3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
